seg_mux_display: RTL and testbench

SEG_MUX_DISPLAY -- requirements
Module: seg_mux_display

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg_mux_display.sv | 137 +++++++++++++
 tb/tb_seg_mux_display.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, bit6=g .. bit0=a) and the
// helper that gives the largest value a given number of decimal digits can show.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // 10^digits - 1; at most 8 digits, so 32 bits is plenty.
   function automatic logic [31:0] max_value(input int digits);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low segment pattern; dash outranks blank.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (dash) begin
         seg = SEG_DASH;
      end else if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg_mux_display.sv
// Binary-to-BCD (sequential double-dabble) feeding a time-multiplexed
// active-low 7-segment display with leading-zero blanking and overflow dashes.
module seg_mux_display
   import seg7_pkg::*;
#(
   parameter int IN_W     = 4,
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   value,
   input  logic              load,
   input  logic              blank_lz,
   output logic              busy,
   output logic              overflow,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + IN_W;
   localparam int BW    = $clog2(IN_W + 1);
   localparam int CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [31:0] MAX_VAL = max_value(DIGITS);

   logic [SR_W-1:0]   sr_reg;
   logic [SR_W-1:0]   sr_adj;
   logic [SR_W-1:0]   sr_next;
   logic [BW-1:0]     bit_cnt_reg;
   logic              busy_reg;
   logic              blz_pend_reg;
   logic              ovf_pend_reg;
   logic [BCD_W-1:0]  disp_bcd_reg;
   logic              disp_blz_reg;
   logic              disp_ovf_reg;
   logic [CW-1:0]     scan_cnt_reg;
   logic [IW-1:0]     idx_reg;
   logic [DIGITS-1:0] an_reg;
   logic [6:0]        seg_reg;

   logic [3:0]        bcd_digit [DIGITS];
   logic [DIGITS:0]   zero_above;
   logic [DIGITS-1:0] blank_vec;
   logic [3:0]        cur_bcd;
   logic              cur_blank;
   logic [6:0]        dec_seg;
   logic [DIGITS-1:0] an_next;

   // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
   always_comb begin
      sr_adj = sr_reg;
      for (int k = 0; k < DIGITS; k++) begin
         if (sr_adj[IN_W + 4*k +: 4] >= 4'd5) begin
            sr_adj[IN_W + 4*k +: 4] = sr_adj[IN_W + 4*k +: 4] + 4'd3;
         end
      end
      sr_next = {sr_adj[SR_W-2:0], 1'b0};
   end

   // zero_above[i] is set when digit i and everything above it are zero.
   assign zero_above[DIGITS] = 1'b1;
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign bcd_digit[gi]  = disp_bcd_reg[4*gi +: 4];
         assign zero_above[gi] = zero_above[gi+1] && (disp_bcd_reg[4*gi +: 4] == 4'd0);
         if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
         end else begin : g_upper
            assign blank_vec[gi] = disp_blz_reg && zero_above[gi];
         end
      end
   endgenerate

   assign cur_bcd   = bcd_digit[idx_reg];
   assign cur_blank = blank_vec[idx_reg];
   assign an_next   = ~(DIGITS'(1) << idx_reg);

   seg7_decode u_decode (
      .bcd   (cur_bcd),
      .blank (cur_blank),
      .dash  (disp_ovf_reg),
      .seg   (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_reg       <= '0;
         bit_cnt_reg  <= '0;
         busy_reg     <= 1'b0;
         blz_pend_reg <= 1'b0;
         ovf_pend_reg <= 1'b0;
         disp_bcd_reg <= '0;
         disp_blz_reg <= 1'b0;
         disp_ovf_reg <= 1'b0;
         scan_cnt_reg <= '0;
         idx_reg      <= '0;
         an_reg       <= '1;
         seg_reg      <= SEG_BLANK;
      end else begin
         if (scan_cnt_reg == CW'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            idx_reg      <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
         end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
         end
         an_reg  <= an_next;
         seg_reg <= dec_seg;

         // A load arriving while busy (including the commit cycle) is dropped.
         if (busy_reg) begin
            sr_reg <= sr_next;
            if (bit_cnt_reg == BW'(IN_W - 1)) begin
               busy_reg     <= 1'b0;
               disp_bcd_reg <= sr_next[SR_W-1 -: BCD_W];
               disp_blz_reg <= blz_pend_reg;
               disp_ovf_reg <= ovf_pend_reg;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
         end else if (load) begin
            sr_reg       <= {{BCD_W{1'b0}}, value};
            bit_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            blz_pend_reg <= blank_lz;
            ovf_pend_reg <= (32'(value) > MAX_VAL);
         end
      end
   end

   assign busy     = busy_reg;
   assign overflow = disp_ovf_reg;
   assign an       = an_reg;
   assign seg      = seg_reg;

endmodule

// File: tb/tb_seg_mux_display.sv
// Directed, table-driven checks of seg_mux_display across three parameter sets.
module tb_seg_mux_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] value_drv = 8'd0;
   logic       blz_drv = 1'b0;
   logic       load4 = 1'b0, load8 = 1'b0, load83 = 1'b0;

   logic       busy4, busy8, busy83, ovf4, ovf8, ovf83;
   logic [1:0] an4, an8;
   logic [2:0] an83;
   logic [6:0] seg4, seg8, seg83;

   int         sel = 0;
   logic [7:0] an_sel;
   logic [6:0] seg_sel;
   logic       busy_sel, ovf_sel;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seg_mux_display #(.IN_W(4), .DIGITS(2), .SCAN_DIV(4)) u4 (
      .clk(clk), .rst(rst), .value(value_drv[3:0]), .load(load4), .blank_lz(blz_drv),
      .busy(busy4), .overflow(ovf4), .an(an4), .seg(seg4));

   seg_mux_display #(.IN_W(8), .DIGITS(2), .SCAN_DIV(4)) u8 (
      .clk(clk), .rst(rst), .value(value_drv), .load(load8), .blank_lz(blz_drv),
      .busy(busy8), .overflow(ovf8), .an(an8), .seg(seg8));

   seg_mux_display #(.IN_W(8), .DIGITS(3), .SCAN_DIV(4)) u83 (
      .clk(clk), .rst(rst), .value(value_drv), .load(load83), .blank_lz(blz_drv),
      .busy(busy83), .overflow(ovf83), .an(an83), .seg(seg83));

   always_comb begin
      an_sel   = {6'h3f, an4};
      seg_sel  = seg4;
      busy_sel = busy4;
      ovf_sel  = ovf4;
      case (sel)
         1: begin an_sel = {6'h3f, an8};  seg_sel = seg8;  busy_sel = busy8;  ovf_sel = ovf8;  end
         2: begin an_sel = {5'h1f, an83}; seg_sel = seg83; busy_sel = busy83; ovf_sel = ovf83; end
         default: ;
      endcase
   end

   typedef struct {
      int unsigned v;
      logic        blz;
      logic        ovf;
      logic [6:0]  s1;
      logic [6:0]  s0;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_load(input int unsigned v, input logic b);
      @(negedge clk);
      value_drv = 8'(v);
      blz_drv   = b;
      case (sel)
         0:       load4  = 1'b1;
         1:       load8  = 1'b1;
         default: load83 = 1'b1;
      endcase
      @(negedge clk);
      load4  = 1'b0;
      load8  = 1'b0;
      load83 = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy_sel === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic read_digit(input int i, output logic [6:0] s);
      logic [7:0] target;
      int n;
      target = ~(8'h01 << i);
      n = 0;
      while (an_sel !== target && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("digit_wait_timeout", 32'(an_sel), 32'(target));
      s = seg_sel;
   endtask

   task automatic run_vec(input int unsigned v, input logic b, input logic ovf, input int ndig,
                          input int inw, input logic [6:0] s2, input logic [6:0] s1,
                          input logic [6:0] s0);
      int n;
      logic [6:0] r2, r1, r0;
      pulse_load(v, b);
      chk("busy_after_load", 32'(busy_sel), 32'd1);
      count_busy(n);
      chk("busy_cycles", 32'(n), 32'(inw));
      repeat (2) @(negedge clk);
      chk("overflow", 32'(ovf_sel), 32'(ovf));
      r2 = SB;
      if (ndig > 2) begin
         read_digit(2, r2);
         chk("digit2", 32'(r2), 32'(s2));
      end
      read_digit(1, r1);
      chk("digit1", 32'(r1), 32'(s1));
      read_digit(0, r0);
      chk("digit0", 32'(r0), 32'(s0));
      $display("dut%0d value=%0d blz=%0b busy=%0d ovf=%0b seg=%b/%b/%b", sel, v, b, n, ovf_sel,
               r2, r1, r0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [6:0] s;

      vecs[0]  = '{13,  1'b0, 1'b0, S1, S3};
      vecs[1]  = '{7,   1'b1, 1'b0, SB, S7};
      vecs[2]  = '{7,   1'b0, 1'b0, S0, S7};
      vecs[3]  = '{150, 1'b0, 1'b1, SD, SD};
      vecs[4]  = '{99,  1'b0, 1'b0, S9, S9};
      vecs[5]  = '{100, 1'b1, 1'b1, SD, SD};
      vecs[6]  = '{0,   1'b1, 1'b0, SB, S0};
      vecs[7]  = '{0,   1'b0, 1'b0, S0, S0};
      vecs[8]  = '{86,  1'b1, 1'b0, S8, S6};
      vecs[9]  = '{45,  1'b0, 1'b0, S4, S5};
      vecs[10] = '{20,  1'b1, 1'b0, S2, S0};

      // Reset state on all three instances.
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         sel = d;
         #1;
         chk("rst_an", 32'(an_sel), 32'hff);
         chk("rst_seg", 32'(seg_sel), 32'(SB));
         chk("rst_busy", 32'(busy_sel), 32'd0);
         chk("rst_ovf", 32'(ovf_sel), 32'd0);
      end
      sel = 0;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_an", 32'(an_sel), 32'hfe);
      chk("post_rst_seg", 32'(seg_sel), 32'(S0));
      $display("reset: an=%b seg=%b", an4, seg4);

      // IN_W=4, DIGITS=2: value 13, then check per-digit hold time.
      sel = 0;
      run_vec(13, 1'b0, 1'b0, 2, 4, SB, S1, S3);
      read_digit(1, s);
      n = 0;
      while (an_sel === 8'hfd && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (an_sel === 8'hfe && n < 50) begin @(negedge clk); n++; end
      chk("digit_hold_cycles", 32'(n), 32'd4);
      $display("dut0 digit0 hold=%0d cycles", n);

      // IN_W=8, DIGITS=2 vector table.
      sel = 1;
      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i].v, vecs[i].blz, vecs[i].ovf, 2, 8, SB, vecs[i].s1, vecs[i].s0);
      end

      // Load while busy (cycle 2 of the conversion) must be ignored.
      pulse_load(42, 1'b0);
      @(negedge clk);
      value_drv = 8'd55;
      load8 = 1'b1;
      @(negedge clk);
      load8 = 1'b0;
      count_busy(n);
      chk("busy_cycles_ignored_load", 32'(n + 2), 32'd8);
      repeat (2) @(negedge clk);
      read_digit(1, s);
      chk("ignored_load_digit1", 32'(s), 32'(S4));
      read_digit(0, s);
      chk("ignored_load_digit0", 32'(s), 32'(S2));
      $display("dut1 load 42 then 55 while busy: busy=%0d digit0=%b", n + 2, s);

      // IN_W=8, DIGITS=3: load repeated on the commit cycle.
      sel = 2;
      pulse_load(255, 1'b0);
      repeat (7) @(negedge clk);
      chk("commit_cycle_busy", 32'(busy_sel), 32'd1);
      value_drv = 8'd17;
      load83 = 1'b1;
      @(negedge clk);
      load83 = 1'b0;
      chk("busy_after_commit", 32'(busy_sel), 32'd0);
      @(negedge clk);
      chk("busy_after_commit_next", 32'(busy_sel), 32'd0);
      @(negedge clk);
      read_digit(2, s);
      chk("commit255_digit2", 32'(s), 32'(S2));
      read_digit(1, s);
      chk("commit255_digit1", 32'(s), 32'(S5));
      read_digit(0, s);
      chk("commit255_digit0", 32'(s), 32'(S5));
      $display("dut2 load 255 with repeat on commit: busy=%0b", busy_sel);
      run_vec(105, 1'b1, 1'b0, 3, 8, S1, S0, S5);
      run_vec(5,   1'b1, 1'b0, 3, 8, SB, SB, S5);

      // Reset two cycles into a conversion of 9 aborts it.
      sel = 0;
      pulse_load(9, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rst_busy", 32'(busy_sel), 32'd0);
      chk("abort_rst_an", 32'(an_sel), 32'hff);
      chk("abort_rst_seg", 32'(seg_sel), 32'(SB));
      rst = 1'b0;
      @(negedge clk);
      chk("abort_an", 32'(an_sel), 32'hfe);
      chk("abort_seg0", 32'(seg_sel), 32'(S0));
      repeat (8) @(negedge clk);
      chk("abort_busy_later", 32'(busy_sel), 32'd0);
      read_digit(1, s);
      chk("abort_digit1", 32'(s), 32'(S0));
      read_digit(0, s);
      chk("abort_digit0", 32'(s), 32'(S0));
      $display("dut0 reset mid-conversion of 9: digit0=%b busy=%0b", s, busy_sel);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
